// File: rtl/dsp48a1_pkg.sv
// ============================================================================
//  Module   : dsp48a1_pkg
//  Brief    : Shared OPMODE field encodings, FSM state type and latency default
//             for the DSP48A1 multiply-accumulate sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dsp48a1_pkg;

  localparam int DSP_LAT_DEF = 3;

  // OPMODE[1:0] selects the X multiplexer, OPMODE[3:2] the Z multiplexer.
  localparam logic [1:0] X_ZERO = 2'b00;
  localparam logic [1:0] X_M    = 2'b01;
  localparam logic [1:0] X_P    = 2'b10;
  localparam logic [1:0] X_DAB  = 2'b11;
  localparam logic [1:0] Z_ZERO = 2'b00;
  localparam logic [1:0] Z_PCIN = 2'b01;
  localparam logic [1:0] Z_P    = 2'b10;
  localparam logic [1:0] Z_C    = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    CLR   = 3'd4
  } state_t;

  function automatic logic [7:0] opmode_word(input logic sub,
                                             input logic [1:0] z,
                                             input logic [1:0] x);
    return {sub, 3'b000, z, x};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mac_tag_pipe.sv
// ============================================================================
//  Module   : mac_tag_pipe
//  Brief    : Shift register of {valid, first} beat tags that tracks operand
//             pairs through the registered stages of the DSP slice.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_tag_pipe #(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic             first_i,
  output logic [DEPTH-1:0] valid_o,
  output logic [DEPTH-1:0] first_o
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] first_q;

  generate
    if (DEPTH > 1) begin : g_shift
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= '0;
          first_q <= '0;
        end else begin
          valid_q <= {valid_q[DEPTH-2:0], valid_i};
          // A bubble never carries the first marker.
          first_q <= {first_q[DEPTH-2:0], first_i & valid_i};
        end
      end
    end else begin : g_single
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= '0;
          first_q <= '0;
        end else begin
          valid_q <= valid_i;
          first_q <= first_i & valid_i;
        end
      end
    end
  endgenerate

  assign valid_o = valid_q;
  assign first_o = first_q;

endmodule

`default_nettype wire

// File: rtl/dsp48a1_mac_ctrl.sv
// ============================================================================
//  Module   : dsp48a1_mac_ctrl
//  Brief    : Streams signed 18x18 operand pairs into one DSP48A1 slice and
//             steers OPMODE / clock enables so that P = sum(A[i]*B[i]).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp48a1_mac_ctrl
  import dsp48a1_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int ACC_SUB = 0,
  parameter int DSP_LAT = DSP_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             s_valid_i,
  input  logic [17:0]      s_a_i,
  input  logic [17:0]      s_b_i,
  output logic             s_ready_o,
  output logic             res_valid_o,
  output logic [47:0]      res_data_o,
  input  logic             res_ready_i,
  output logic             busy_o,
  output logic [17:0]      dsp_a_o,
  output logic [17:0]      dsp_b_o,
  output logic [7:0]       dsp_opmode_o,
  output logic             dsp_cea_o,
  output logic             dsp_ceb_o,
  output logic             dsp_cem_o,
  output logic             dsp_ceopmode_o,
  output logic             dsp_cep_o,
  output logic             dsp_rst_o,
  input  logic [47:0]      dsp_p_i
);

  localparam int   DEPTH   = DSP_LAT - 1;
  localparam logic SUB_BIT = (ACC_SUB != 0);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             first_q, first_d;
  logic [7:0]       opmode_q;
  logic [7:0]       opmode_beat;
  logic [DEPTH-1:0] tag_valid;
  logic [DEPTH-1:0] tag_first;
  logic             beat;
  logic             unused_first;

  assign beat = (state_q == RUN) && s_valid_i;

  mac_tag_pipe #(
    .DEPTH(DEPTH)
  ) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .valid_i(beat),
    .first_i(first_q),
    .valid_o(tag_valid),
    .first_o(tag_first)
  );

  // Only the tag that lines up with the slice's M register steers OPMODE.
  assign unused_first = ^tag_first;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    first_d = first_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_d = RUN;
            rem_d   = len_i;
            first_d = 1'b1;
          end else begin
            state_d = CLR;
          end
        end
      end
      RUN: begin
        if (beat) begin
          rem_d   = rem_q - 1'b1;
          first_d = 1'b0;
          if (rem_q == LEN_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (tag_valid == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready_i) begin
          state_d = IDLE;
        end
      end
      CLR: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      first_q  <= 1'b0;
      opmode_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      first_q  <= first_d;
      opmode_q <= dsp_opmode_o;
    end
  end

  // First beat loads P with M alone; later beats accumulate onto P.
  assign opmode_beat  = opmode_word(SUB_BIT,
                                    tag_first[DEPTH-2] ? Z_ZERO : Z_P, X_M);
  assign dsp_opmode_o = tag_valid[DEPTH-2] ? opmode_beat : opmode_q;
  assign dsp_cep_o    = tag_valid[DEPTH-1];

  assign dsp_a_o        = s_a_i;
  assign dsp_b_o        = s_b_i;
  assign dsp_cea_o      = 1'b1;
  assign dsp_ceb_o      = 1'b1;
  assign dsp_cem_o      = 1'b1;
  assign dsp_ceopmode_o = 1'b1;
  // CLR wipes P so a zero-length job reports 0.
  assign dsp_rst_o      = rst || (state_q == CLR);

  assign s_ready_o   = (state_q == RUN);
  assign res_valid_o = (state_q == DONE);
  assign res_data_o  = dsp_p_i;
  assign busy_o      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dsp48a1_mac_ctrl.sv
// ============================================================================
//  Module   : tb_dsp48a1_mac_ctrl
//  Brief    : Two sequencers (add and subtract accumulate) each driving a
//             behavioural DSP48A1 slice; results checked against a scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dsp48a1_mac_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] len;
  logic        s_valid;
  logic [17:0] s_a;
  logic [17:0] s_b;
  logic        res_ready;

  logic        s_ready   [2];
  logic        res_valid [2];
  logic [47:0] res_data  [2];
  logic        busy      [2];
  logic [17:0] dsp_a     [2];
  logic [17:0] dsp_b     [2];
  logic [7:0]  dsp_opmode[2];
  logic        cea       [2];
  logic        ceb       [2];
  logic        cem       [2];
  logic        ceop      [2];
  logic        cep       [2];
  logic        drst      [2];

  always #5 clk = ~clk;

  // Instance 0 adds, instance 1 subtracts; both see identical stimulus.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      logic signed [17:0] a1;
      logic signed [17:0] b1;
      logic signed [35:0] m;
      logic [7:0]         opm;
      logic [47:0]        p;
      logic [47:0]        xmux;
      logic [47:0]        zmux;

      dsp48a1_mac_ctrl #(
        .LEN_W  (16),
        .ACC_SUB(gi),
        .DSP_LAT(3)
      ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .len_i         (len),
        .s_valid_i     (s_valid),
        .s_a_i         (s_a),
        .s_b_i         (s_b),
        .s_ready_o     (s_ready[gi]),
        .res_valid_o   (res_valid[gi]),
        .res_data_o    (res_data[gi]),
        .res_ready_i   (res_ready),
        .busy_o        (busy[gi]),
        .dsp_a_o       (dsp_a[gi]),
        .dsp_b_o       (dsp_b[gi]),
        .dsp_opmode_o  (dsp_opmode[gi]),
        .dsp_cea_o     (cea[gi]),
        .dsp_ceb_o     (ceb[gi]),
        .dsp_cem_o     (cem[gi]),
        .dsp_ceopmode_o(ceop[gi]),
        .dsp_cep_o     (cep[gi]),
        .dsp_rst_o     (drst[gi]),
        .dsp_p_i       (p)
      );

      always_comb begin
        case (opm[1:0])
          2'b01:   xmux = {{12{m[35]}}, m};
          2'b10:   xmux = p;
          default: xmux = '0;
        endcase
        zmux = (opm[3:2] == 2'b10) ? p : 48'd0;
      end

      // A1/B1 -> M -> P with a registered OPMODE, all reset by dsp_rst.
      always @(posedge clk) begin
        if (drst[gi]) begin
          a1  <= '0;
          b1  <= '0;
          m   <= '0;
          opm <= '0;
          p   <= '0;
        end else begin
          if (cea[gi])  a1  <= dsp_a[gi];
          if (ceb[gi])  b1  <= dsp_b[gi];
          if (cem[gi])  m   <= a1 * b1;
          if (ceop[gi]) opm <= dsp_opmode[gi];
          if (cep[gi])  p   <= opm[7] ? (zmux - xmux) : (zmux + xmux);
        end
      end
    end
  endgenerate

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          cep_total = 0;
  int          cep_base = 0;
  int          acc_cyc = 0;
  int          start_cyc = 0;
  int          ja[8];
  int          jb[8];
  logic [47:0] exp0[$];
  logic [47:0] exp1[$];
  logic [47:0] last_exp0;
  logic [47:0] last_exp1;
  logic        rv_prev[2] = '{1'b0, 1'b0};

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cep[0]) cep_total <= cep_total + 1;
    if (res_valid[0] && !rv_prev[0]) begin
      if (exp0.size() == 0) check_eq("sb0_unexpected", 1, 0);
      else                  check_eq("sb0_result", res_data[0], exp0.pop_front());
    end
    if (res_valid[1] && !rv_prev[1]) begin
      if (exp1.size() == 0) check_eq("sb1_unexpected", 1, 0);
      else                  check_eq("sb1_result", res_data[1], exp1.pop_front());
    end
    rv_prev[0] <= res_valid[0];
    rv_prev[1] <= res_valid[1];
  end

  task automatic start_job(input int n, input bit push);
    longint sum = 0;
    longint nsum;
    for (int i = 0; i < n; i++) sum += longint'(ja[i]) * longint'(jb[i]);
    nsum = -sum;
    if (push) begin
      last_exp0 = sum[47:0];
      last_exp1 = nsum[47:0];
      exp0.push_back(last_exp0);
      exp1.push_back(last_exp1);
    end
    cep_base  = cep_total;
    start     = 1'b1;
    len       = 16'(n);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    len   = '0;
    check_eq("busy_after_start", busy[0], 1);
    check_eq("clr_dsp_rst", drst[0], (n == 0));
  endtask

  task automatic drive_beats(input int n, input bit bubbles);
    int i = 0;
    int guard = 0;
    bit hole = 1'b0;
    bit acc;
    while (i < n && guard < 100) begin
      s_valid = !(bubbles && hole);
      s_a     = 18'(ja[i]);
      s_b     = 18'(jb[i]);
      hole    = !hole;
      acc     = s_valid && s_ready[0];
      if (acc) acc_cyc = cyc;
      @(posedge clk); #1;
      guard++;
      if (acc) begin
        if (i == 0) begin
          check_eq("opmode_first_add", dsp_opmode[0], 8'h01);
          check_eq("opmode_first_sub", dsp_opmode[1], 8'h81);
        end else if (i == 1 && !bubbles) begin
          check_eq("opmode_acc_add", dsp_opmode[0], 8'h09);
          check_eq("opmode_acc_sub", dsp_opmode[1], 8'h89);
        end
        i++;
      end
    end
    s_valid = 1'b0;
    check_eq("beats_accepted", i, n);
  endtask

  task automatic finish_job(input int n, input int hold, input bit keep);
    int w = 0;
    while (res_valid[0] !== 1'b1 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check_eq("res_valid_seen", res_valid[0], 1);
    if (n > 0) check_eq("latency_last_beat", cyc - acc_cyc, 4);
    else       check_eq("latency_zero_len", cyc - start_cyc, 2);
    check_eq("cep_pulses", cep_total - cep_base, n);
    check_eq("s_ready_in_done", s_ready[0], 0);
    for (int h = 0; h < hold; h++) begin
      if (h == 1) begin
        start = 1'b1;
        len   = 16'd3;
      end
      @(posedge clk); #1;
      start = 1'b0;
      len   = '0;
      check_eq("hold_valid", res_valid[0], 1);
      check_eq("hold_data_add", res_data[0], last_exp0);
      check_eq("hold_data_sub", res_data[1], last_exp1);
    end
    if (!keep) res_ready = 1'b1;
    @(posedge clk); #1;
    if (!keep) res_ready = 1'b0;
    check_eq("idle_after_result", busy[0], 0);
    check_eq("res_valid_dropped", res_valid[0], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    s_valid   = 1'b0;
    s_a       = '0;
    s_b       = '0;
    res_ready = 1'b0;
    ja        = '{default: 0};
    jb        = '{default: 0};
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_s_ready", s_ready[0], 0);
    check_eq("rst_res_valid", res_valid[0], 0);
    check_eq("rst_busy", busy[0], 0);
    check_eq("rst_opmode", dsp_opmode[0], 0);
    check_eq("rst_cep", cep[0], 0);
    check_eq("rst_dsp_rst", drst[0], 1);
    check_eq("ce_tied", {cea[0], ceb[0], cem[0], ceop[0]}, 4'hF);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("dsp_rst_released", drst[0], 0);

    // Back-to-back 4-beat job.
    ja = '{1, 3, 5, 7, 0, 0, 0, 0};
    jb = '{2, 4, 6, 8, 0, 0, 0, 0};
    start_job(4, 1'b1);
    drive_beats(4, 1'b0);
    finish_job(4, 0, 1'b0);

    // Same job with a bubble after every beat.
    start_job(4, 1'b1);
    drive_beats(4, 1'b1);
    finish_job(4, 0, 1'b0);

    // Extreme signed operands.
    ja = '{-131072, -5, 0, 0, 0, 0, 0, 0};
    jb = '{131071, 3, 0, 0, 0, 0, 0, 0};
    start_job(2, 1'b1);
    drive_beats(2, 1'b0);
    finish_job(2, 0, 1'b0);

    // Zero-length job, result held under back-pressure with a stray start.
    start_job(0, 1'b1);
    finish_job(0, 5, 1'b0);

    // Abort mid-job with reset, then a clean single-beat job.
    ja = '{1, 3, 5, 7, 0, 0, 0, 0};
    jb = '{2, 4, 6, 8, 0, 0, 0, 0};
    start_job(4, 1'b0);
    drive_beats(2, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_s_ready", s_ready[0], 0);
    check_eq("abort_res_valid", res_valid[0], 0);
    check_eq("abort_busy", busy[0], 0);
    check_eq("abort_opmode", dsp_opmode[0], 0);
    check_eq("abort_cep", cep[0], 0);
    check_eq("abort_dsp_rst", drst[0], 1);
    rst = 1'b0;
    @(posedge clk); #1;
    ja = '{9, 0, 0, 0, 0, 0, 0, 0};
    jb = '{9, 0, 0, 0, 0, 0, 0, 0};
    start_job(1, 1'b1);
    drive_beats(1, 1'b0);
    finish_job(1, 0, 1'b0);

    // Two consecutive jobs with res_ready held high.
    res_ready = 1'b1;
    ja = '{1, 1, 1, 0, 0, 0, 0, 0};
    jb = '{1, 1, 1, 0, 0, 0, 0, 0};
    start_job(2, 1'b1);
    drive_beats(2, 1'b0);
    finish_job(2, 0, 1'b1);
    start_job(3, 1'b1);
    drive_beats(3, 1'b0);
    finish_job(3, 0, 1'b1);
    res_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("sb0_drained", exp0.size(), 0);
    check_eq("sb1_drained", exp1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
